// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq -- sequential shift-and-add multiplier coprocessor.
//
// The Hack ALU (module ALU, kept in this file) is the only adder. Each
// accumulate step and each multiplicand doubling is one ALU add, so one
// multiplier bit takes two cycles (ADD then DBL). The result is the low WIDTH
// bits of a*b. Two's-complement and unsigned operands give the same low bits.
//
// Ports (alu_mul_seq):
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset
//   start    in   request pulse, sampled only while busy=0
//   a, b     in   multiplicand / multiplier, latched when start is accepted
//   busy     out  high while an operation is in progress (registered)
//   done     out  one-cycle pulse when product is valid (registered)
//   product  out  low WIDTH bits of a*b, held until the next done
//   zr, ng   out  product==0 / product sign bit, held with product
//
// Ports (ALU): x, y operands; zx/nx/zy/ny/f/no Hack control bits;
//   out result; zr/ng result flags.
// ---------------------------------------------------------------------------

module ALU #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] y_s;
    logic [WIDTH-1:0] f_s;
    logic [WIDTH-1:0] out_s;

    // Hack ALU: optional zero/invert of each operand, add or AND, optional
    // invert of the result.
    always_comb begin
        x_s   = zx ? {WIDTH{1'b0}} : x;
        x_s   = nx ? ~x_s : x_s;
        y_s   = zy ? {WIDTH{1'b0}} : y;
        y_s   = ny ? ~y_s : y_s;
        f_s   = f ? (x_s + y_s) : (x_s & y_s);
        out_s = no ? ~f_s : f_s;
    end

    assign out = out_s;
    assign zr  = (out_s == {WIDTH{1'b0}});
    assign ng  = out_s[WIDTH-1];

endmodule

module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             zr,
    output logic             ng
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DBL  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] product_r;
    logic             zr_r;
    logic             ng_r;

    logic [WIDTH-1:0] alu_x_s;
    logic [WIDTH-1:0] alu_y_s;
    logic [WIDTH-1:0] alu_out_s;
    logic             alu_zr_s;
    logic             alu_ng_s;
    logic             alu_flags_unused_s;

    // ALU operand select: accumulate in ADD, self-add (doubling) in DBL.
    always_comb begin
        alu_x_s = {WIDTH{1'b0}};
        alu_y_s = {WIDTH{1'b0}};
        case (state_r)
            ST_ADD: begin
                alu_x_s = acc_r;
                alu_y_s = mcand_r;
            end
            ST_DBL: begin
                alu_x_s = mcand_r;
                alu_y_s = mcand_r;
            end
            default: begin
                alu_x_s = {WIDTH{1'b0}};
                alu_y_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Control bits hard-wired to x+y.
    ALU #(.WIDTH(WIDTH)) u_alu (
        .x   (alu_x_s),
        .y   (alu_y_s),
        .zx  (1'b0),
        .nx  (1'b0),
        .zy  (1'b0),
        .ny  (1'b0),
        .f   (1'b1),
        .no  (1'b0),
        .out (alu_out_s),
        .zr  (alu_zr_s),
        .ng  (alu_ng_s)
    );

    // The ALU flags describe the intermediate sum, not the final product.
    assign alu_flags_unused_s = alu_zr_s ^ alu_ng_s;

    // Multiplier FSM with all outputs registered; busy tracks next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {WIDTH{1'b0}};
            zr_r      <= 1'b1;
            ng_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= a;
                        mplier_r <= b;
                        acc_r    <= {WIDTH{1'b0}};
                        state_r  <= ST_ADD;
                        busy_r   <= 1'b1;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_ADD: begin
                    // Loop ends once no multiplier bits remain, so short
                    // multipliers finish early.
                    if (mplier_r == {WIDTH{1'b0}}) begin
                        product_r <= acc_r;
                        zr_r      <= (acc_r == {WIDTH{1'b0}});
                        ng_r      <= acc_r[WIDTH-1];
                        done_r    <= 1'b1;
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                    end else begin
                        if (mplier_r[0]) begin
                            acc_r <= alu_out_s;
                        end else begin
                            acc_r <= acc_r;
                        end
                        state_r <= ST_DBL;
                        busy_r  <= 1'b1;
                    end
                end
                ST_DBL: begin
                    // Doubling may wrap to zero; later adds then contribute 0.
                    mcand_r  <= alu_out_s;
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    state_r  <= ST_ADD;
                    busy_r   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;
    assign zr      = zr_r;
    assign ng      = ng_r;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic             zr;
    logic             ng;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mul_seq #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .zr      (zr),
        .ng      (ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Number of multiplier bits that must be consumed: highest set bit + 1.
    function automatic int bits_used(input logic [WIDTH-1:0] v);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) return i + 1;
        end
        return 0;
    endfunction

    // ---------------- behavioural model ----------------
    bit               m_live = 1'b0;
    bit               m_busy = 1'b0;
    bit               m_done = 1'b0;
    int               m_rem  = 0;
    logic [WIDTH-1:0] m_prod = '0;
    logic [WIDTH-1:0] m_pend = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_live = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_rem  = 0;
            m_prod = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_prod = m_pend;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_pend = a * b;
                m_rem  = 2 * bits_used(b) + 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            check("busy",    int'(busy),    int'(m_busy));
            check("done",    int'(done),    int'(m_done));
            check("product", int'(product), int'(m_prod));
            check("zr",      int'(zr),      int'(m_prod == '0));
            check("ng",      int'(ng),      int'(m_prod[WIDTH-1]));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one operation and wait for done; optionally pulse a second start
    // (a=1, b=1) at cycle 'intr' after the first start.
    task automatic op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                      input logic [WIDTH-1:0] ep, input logic ez, input logic en,
                      input int el, input int intr);
        int lat;
        start = 1'b1;
        a     = ta;
        b     = tb;
        tick();
        start = 1'b0;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        lat   = 1;
        while (!done && lat < 40) begin
            if (lat == intr) begin
                start = 1'b1;
                a     = 16'h0001;
                b     = 16'h0001;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check("latency",    lat,          el);
        check("op_product", int'(product), int'(ep));
        check("op_zr",      int'(zr),      int'(ez));
        check("op_ng",      int'(ng),      int'(en));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_product", int'(product), 0);
        check("rst_zr",      int'(zr),      1);
        check("rst_ng",      int'(ng),      0);

        // 1: 3*5
        op(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 8, 0);
        tick();
        // 2: back-to-back, second start in the done cycle
        op(16'h0011, 16'h0003, 16'h0033, 1'b0, 1'b0, 6, 0);
        op(16'hFFFF, 16'h0002, 16'hFFFE, 1'b0, 1'b1, 6, 0);
        tick();
        // 3: zero multiplier, then wrap to zero at full length
        op(16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 2, 0);
        tick();
        op(16'h0002, 16'h8000, 16'h0000, 1'b1, 1'b0, 34, 0);
        tick();
        // 4: start while busy is ignored
        op(16'h0007, 16'h0009, 16'h003F, 1'b0, 1'b0, 10, 3);
        tick();
        check("t4_idle", int'(busy), 0);

        // 5: reset mid-operation aborts
        start = 1'b1;
        a     = 16'h00FF;
        b     = 16'h00FF;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy",    int'(busy),    0);
        check("abort_product", int'(product), 0);
        check("abort_zr",      int'(zr),      1);
        begin
            int seen = 0;
            for (int i = 0; i < 30; i++) begin
                if (done) seen++;
                tick();
            end
            check("abort_no_done", seen, 0);
        end
        op(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 34, 0);
        tick();

        // Random traffic, including starts while busy and rare resets.
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 2) == 0);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom) >> $urandom_range(0, 15);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 40; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
